// File: rtl/pcap_frame_engine.sv
// pcap_frame_engine
//   Position-capture front end. Edge-detects enable/frame/capture, latches NCH
//   32-bit channel values and serialises each sample into a word FIFO that
//   drains through a first-word-fall-through valid/ready stream.
//
//   Optional feature macro: PCAP_FRAME_TIMESTAMP_EN
//     defined   - a 32-bit cycle counter (cleared on RUN entry) is appended as
//                 the last word of every sample, NW = NCH+1
//     undefined - NW = NCH
//
// Ports
//   clk_i, reset_i        clock, synchronous active-high reset
//   arm_i, disarm_i       one-cycle control pulses (disarm wins)
//   enable_i              capture gate (level)
//   frame_i, capture_i    rising-edge strobes
//   mode_i                0 immediate, 1 framed, 2 framed-difference, 3 as 0
//   value_i               NCH packed 32-bit channel values
//   dout_o/dout_valid_o/dout_ready_i   output stream
//   active_o              high in ARMED or RUN
//   err_o                 0 none, 1 overflow, 2 double capture, 3 too fast
//   sample_count_o        completed samples since arm (saturating)

module pcap_frame_engine #(
    parameter int unsigned NCH        = 4,
    parameter int unsigned FIFO_DEPTH = 32,
    parameter int unsigned CNT_W      = 32
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              arm_i,
    input  logic              disarm_i,
    input  logic              enable_i,
    input  logic              frame_i,
    input  logic              capture_i,
    input  logic [1:0]        mode_i,
    input  logic [NCH*32-1:0] value_i,
    output logic [31:0]       dout_o,
    output logic              dout_valid_o,
    input  logic              dout_ready_i,
    output logic              active_o,
    output logic [1:0]        err_o,
    output logic [CNT_W-1:0]  sample_count_o
);

`ifdef PCAP_FRAME_TIMESTAMP_EN
    localparam int unsigned NW = NCH + 1;
`else
    localparam int unsigned NW = NCH;
`endif
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    // Highest fill level at which a whole sample still fits.
    localparam logic [CW-1:0] MAX_START_CNT = CW'(FIFO_DEPTH - NW);

    typedef enum logic [1:0] {StIdle, StArmed, StRun} state_e;

    state_e            state_q, state_d;
    logic              en_q, frame_q, cap_q;
    logic [1:0]        mode_q;
    logic [1:0]        err_q;
    logic [CNT_W-1:0]  sample_cnt_q;
    logic              pend_q;
    logic [31:0]       pend_slot_q [NCH];
    logic [31:0]       fstart_q    [NCH];
    logic [31:0]       out_slot_q  [NW];
    logic              start_q, busy_q;
    logic [IW-1:0]     idx_q;
    logic [31:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
`ifdef PCAP_FRAME_TIMESTAMP_EN
    logic [31:0]       ts_q, pend_ts_q;
`endif

    logic arm_ok, run_entry, en_fall, cap_hit, frame_hit, framed, ser_busy;
    logic imm_take, imm_fast, emit, frame_fast, dbl_cap, pend_fill;
    logic has_room, overflow, last_wr, rd_en, wr_en;
    logic [1:0] err_new;

    assign arm_ok    = (state_q == StIdle) && arm_i && !disarm_i;
    assign run_entry = (state_q == StArmed) && !disarm_i && enable_i;
    assign en_fall   = en_q && !enable_i;
    // Once an error is latched no new sample may start; the run is winding down.
    assign cap_hit   = (state_q == StRun) && (err_q == 2'd0) && enable_i && capture_i && !cap_q;
    assign frame_hit = (state_q == StRun) && (err_q == 2'd0) && frame_i && !frame_q;
    assign framed    = (mode_q != 2'd0);
    assign ser_busy  = start_q || busy_q;

    assign imm_take   = cap_hit && !framed && !ser_busy;
    assign imm_fast   = cap_hit && !framed && ser_busy;
    assign emit       = frame_hit && framed && pend_q && !ser_busy;
    assign frame_fast = frame_hit && framed && pend_q && ser_busy;
    // A frame in the same cycle empties the slot first, so the capture is legal.
    assign dbl_cap    = cap_hit && framed && pend_q && !frame_hit;
    assign pend_fill  = cap_hit && framed && (!pend_q || frame_hit);

    assign has_room = (count_q <= MAX_START_CNT);
    assign overflow = start_q && !has_room;
    assign wr_en    = busy_q;
    assign last_wr  = busy_q && (idx_q == IW'(NW - 1));
    assign rd_en    = dout_valid_o && dout_ready_i;

    always_comb begin
        err_new = 2'd0;
        if (overflow)                    err_new = 2'd1;
        else if (dbl_cap)                err_new = 2'd2;
        else if (imm_fast || frame_fast) err_new = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (arm_ok) state_d = StArmed;
            StArmed: begin
                if (disarm_i)      state_d = StIdle;
                else if (enable_i) state_d = StRun;
            end
            StRun: begin
                if (disarm_i || en_fall)                     state_d = StIdle;
                else if ((err_q != 2'd0) && !ser_busy)       state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            en_q         <= 1'b0;
            frame_q      <= 1'b0;
            cap_q        <= 1'b0;
            mode_q       <= 2'd0;
            err_q        <= 2'd0;
            sample_cnt_q <= '0;
            pend_q       <= 1'b0;
            start_q      <= 1'b0;
            busy_q       <= 1'b0;
            idx_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            for (int c = 0; c < NCH; c++) begin
                pend_slot_q[c] <= '0;
                fstart_q[c]    <= '0;
            end
            for (int w = 0; w < NW; w++) out_slot_q[w] <= '0;
`ifdef PCAP_FRAME_TIMESTAMP_EN
            ts_q      <= '0;
            pend_ts_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            en_q    <= enable_i;
            frame_q <= frame_i;
            cap_q   <= capture_i;

            if (arm_ok) begin
                mode_q <= (mode_i == 2'd3) ? 2'd0 : mode_i;
                err_q  <= 2'd0;
            end else if (err_q == 2'd0) begin
                err_q <= err_new;
            end

            if (arm_ok) sample_cnt_q <= '0;
            else if (last_wr && !(&sample_cnt_q)) sample_cnt_q <= sample_cnt_q + 1'b1;

            if (run_entry || frame_hit) begin
                for (int c = 0; c < NCH; c++) fstart_q[c] <= value_i[32*c +: 32];
            end

            if (arm_ok) pend_q <= 1'b0;
            else if (pend_fill) pend_q <= 1'b1;
            else if (frame_hit && framed) pend_q <= 1'b0;

            if (pend_fill) begin
                for (int c = 0; c < NCH; c++) begin
                    // With a coincident frame the new reference is this cycle's value.
                    if (mode_q == 2'd2)
                        pend_slot_q[c] <= value_i[32*c +: 32] -
                                          (frame_hit ? value_i[32*c +: 32] : fstart_q[c]);
                    else
                        pend_slot_q[c] <= value_i[32*c +: 32];
                end
`ifdef PCAP_FRAME_TIMESTAMP_EN
                pend_ts_q <= ts_q;
`endif
            end

            if (imm_take) begin
                for (int c = 0; c < NCH; c++) out_slot_q[c] <= value_i[32*c +: 32];
`ifdef PCAP_FRAME_TIMESTAMP_EN
                out_slot_q[NW-1] <= ts_q;
`endif
            end else if (emit) begin
                for (int c = 0; c < NCH; c++) out_slot_q[c] <= pend_slot_q[c];
`ifdef PCAP_FRAME_TIMESTAMP_EN
                out_slot_q[NW-1] <= pend_ts_q;
`endif
            end

`ifdef PCAP_FRAME_TIMESTAMP_EN
            ts_q <= run_entry ? 32'd0 : ts_q + 32'd1;
`endif

            // Serialiser: one cycle for the room check, then one word per cycle.
            start_q <= imm_take || emit;
            if (start_q && has_room) begin
                busy_q <= 1'b1;
                idx_q  <= '0;
            end else if (busy_q) begin
                if (last_wr) busy_q <= 1'b0;
                idx_q <= idx_q + 1'b1;
            end

            if (wr_en) begin
                mem_q[wr_ptr_q] <= out_slot_q[idx_q];
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
            if (wr_en && !rd_en)      count_q <= count_q + 1'b1;
            else if (rd_en && !wr_en) count_q <= count_q - 1'b1;
        end
    end

    assign dout_valid_o   = (count_q != '0);
    assign dout_o         = dout_valid_o ? mem_q[rd_ptr_q] : 32'd0;
    assign active_o       = (state_q != StIdle);
    assign err_o          = err_q;
    assign sample_count_o = sample_cnt_q;

endmodule

// File: tb/tb_pcap_frame_engine.sv
// Directed bench for pcap_frame_engine (NCH=4, FIFO_DEPTH=32, default build).
module tb_pcap_frame_engine;
    localparam int unsigned NCH = 4;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              arm_i = 1'b0, disarm_i = 1'b0;
    logic              enable_i = 1'b0, frame_i = 1'b0, capture_i = 1'b0;
    logic [1:0]        mode_i = 2'd0;
    logic [NCH*32-1:0] value_i = '0;
    logic [31:0]       dout_o;
    logic              dout_valid_o;
    logic              dout_ready_i = 1'b0;
    logic              active_o;
    logic [1:0]        err_o;
    logic [31:0]       sample_count_o;

    int n_chk  = 0;
    int n_pass = 0;
    logic [31:0] exp_w [64];

    pcap_frame_engine #(.NCH(4), .FIFO_DEPTH(32), .CNT_W(32)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .arm_i          (arm_i),
        .disarm_i       (disarm_i),
        .enable_i       (enable_i),
        .frame_i        (frame_i),
        .capture_i      (capture_i),
        .mode_i         (mode_i),
        .value_i        (value_i),
        .dout_o         (dout_o),
        .dout_valid_o   (dout_valid_o),
        .dout_ready_i   (dout_ready_i),
        .active_o       (active_o),
        .err_o          (err_o),
        .sample_count_o (sample_count_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #400000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Sample point: 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic arm(input logic [1:0] m);
        mode_i = m;
        arm_i  = 1'b1;
        tick();
        arm_i  = 1'b0;
    endtask

    task automatic pulse_cap();
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        tick();
    endtask

    task automatic pulse_frame();
        frame_i = 1'b1;
        tick();
        frame_i = 1'b0;
        tick();
    endtask

    task automatic set_all(input logic [31:0] v);
        value_i = {NCH{v}};
    endtask

    // Drain n words with ready held high, then require an empty FIFO.
    task automatic drain(input string tag, input int n);
        dout_ready_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            chk({tag, "_valid"}, {31'd0, dout_valid_o}, 32'd1);
            chk({tag, "_data"}, dout_o, exp_w[i]);
            tick();
        end
        chk({tag, "_empty"}, {31'd0, dout_valid_o}, 32'd0);
        dout_ready_i = 1'b0;
    endtask

    initial begin
        // Reset state
        tick(2);
        reset_i = 1'b0;
        tick();
        chk("rst_valid", {31'd0, dout_valid_o}, 32'd0);
        chk("rst_dout", dout_o, 32'd0);
        chk("rst_active", {31'd0, active_o}, 32'd0);
        chk("rst_err", {30'd0, err_o}, 32'd0);
        chk("rst_count", sample_count_o, 32'd0);

        // 1: mode 0 immediate capture, latency and word order
        value_i = {32'h44, 32'h33, 32'h22, 32'h11};
        dout_ready_i = 1'b1;
        arm(2'd0);
        chk("t1_armed", {31'd0, active_o}, 32'd1);
        enable_i = 1'b1;
        tick();
        capture_i = 1'b1;
        tick();                       // edge-sampling clock
        capture_i = 1'b0;
        chk("t1_lat0", {31'd0, dout_valid_o}, 32'd0);
        tick();
        chk("t1_lat1", {31'd0, dout_valid_o}, 32'd0);
        tick();
        exp_w[0] = 32'h11; exp_w[1] = 32'h22; exp_w[2] = 32'h33; exp_w[3] = 32'h44;
        drain("t1", 4);
        chk("t1_count", sample_count_o, 32'd1);
        chk("t1_err", {30'd0, err_o}, 32'd0);
        enable_i = 1'b0;
        tick();
        chk("t1_idle", {31'd0, active_o}, 32'd0);

        // 2: mode 1 framed capture; a frame with nothing pending emits nothing
        arm(2'd1);
        enable_i = 1'b1;
        tick();
        value_i = {32'd103, 32'd102, 32'd101, 32'd100};
        pulse_cap();
        set_all(32'hDEAD_BEEF);
        tick(4);
        chk("t2_no_early", {31'd0, dout_valid_o}, 32'd0);
        pulse_frame();
        tick(6);
        pulse_frame();
        tick(6);
        chk("t2_err", {30'd0, err_o}, 32'd0);
        chk("t2_count", sample_count_o, 32'd1);
        for (int c = 0; c < 4; c++) exp_w[c] = 32'd100 + c;
        drain("t2", 4);
        enable_i = 1'b0;
        tick();

        // 3: mode 2 framed difference, including wrap-around
        arm(2'd2);
        set_all(32'd1000);
        enable_i = 1'b1;
        tick();
        pulse_frame();
        set_all(32'd1250);
        pulse_cap();
        set_all(32'd7777);
        pulse_frame();
        tick(6);
        set_all(32'h10);
        pulse_frame();
        set_all(32'h5);
        pulse_cap();
        pulse_frame();
        tick(6);
        chk("t3_count", sample_count_o, 32'd2);
        chk("t3_err", {30'd0, err_o}, 32'd0);
        for (int c = 0; c < 4; c++) begin
            exp_w[c]     = 32'd250;
            exp_w[4 + c] = 32'hFFFF_FFF5;
        end
        drain("t3", 8);
        enable_i = 1'b0;
        tick();

        // 4: overflow with the stream stalled
        arm(2'd0);
        enable_i = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            for (int c = 0; c < 4; c++) begin
                value_i[32*c +: 32] = k * 256 + c;
                exp_w[4*k + c]      = k * 256 + c;
            end
            pulse_cap();
            tick(6);
        end
        chk("t4_err", {30'd0, err_o}, 32'd1);
        chk("t4_idle", {31'd0, active_o}, 32'd0);
        chk("t4_count", sample_count_o, 32'd8);
        tick(3);
        chk("t4_hold", dout_o, 32'h0);
        drain("t4", 32);
        enable_i = 1'b0;
        tick();

        // 5a: capture too fast in mode 0
        arm(2'd0);
        chk("t5_err_clr", {30'd0, err_o}, 32'd0);
        enable_i = 1'b1;
        tick();
        set_all(32'hA5A5_0001);
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        set_all(32'hA5A5_0002);
        tick();
        capture_i = 1'b1;
        tick();
        capture_i = 1'b0;
        tick(10);
        chk("t5_err3", {30'd0, err_o}, 32'd3);
        chk("t5_idle", {31'd0, active_o}, 32'd0);
        chk("t5_count", sample_count_o, 32'd1);
        for (int c = 0; c < 4; c++) exp_w[c] = 32'hA5A5_0001;
        drain("t5", 4);
        enable_i = 1'b0;
        tick();

        // 5b: two captures in one frame
        arm(2'd1);
        enable_i = 1'b1;
        tick();
        pulse_cap();
        tick(2);
        pulse_cap();
        tick(4);
        chk("t5b_err2", {30'd0, err_o}, 32'd2);
        chk("t5b_idle", {31'd0, active_o}, 32'd0);
        chk("t5b_nodata", {31'd0, dout_valid_o}, 32'd0);
        enable_i = 1'b0;
        tick();

        // 6: reset mid-serialisation
        arm(2'd0);
        enable_i = 1'b1;
        tick();
        set_all(32'h0BAD_F00D);
        pulse_cap();
        tick();
        chk("t6_pre_valid", {31'd0, dout_valid_o}, 32'd1);
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        chk("t6_valid", {31'd0, dout_valid_o}, 32'd0);
        chk("t6_dout", dout_o, 32'd0);
        chk("t6_active", {31'd0, active_o}, 32'd0);
        chk("t6_err", {30'd0, err_o}, 32'd0);
        chk("t6_count", sample_count_o, 32'd0);
        tick(6);
        chk("t6_still_empty", {31'd0, dout_valid_o}, 32'd0);

        // 6b: arm and disarm together
        enable_i = 1'b0;
        arm_i    = 1'b1;
        disarm_i = 1'b1;
        tick();
        arm_i    = 1'b0;
        disarm_i = 1'b0;
        chk("t6b_active", {31'd0, active_o}, 32'd0);
        tick();
        chk("t6b_active2", {31'd0, active_o}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pcap_frame_engine.md
Name: pcap_frame_engine

Overview:
Parametrised position-capture front end that generalises the single-channel enable/capture framing flow to NCH channels with selectable capture modes. It edge-detects enable/frame/capture (driven from ttlin pads or the bit bus), latches NCH 32-bit position values, and serialises them into a word FIFO. The FIFO drains through a valid/ready stream into the PCAP DMA path.

Parameters:
NCH, 4, number of 32-bit capture channels (1..16)
FIFO_DEPTH, 32, output FIFO depth in words; power of 2, >= 2*NCH+2
CNT_W, 32, width of sample counter

Ports:
clk_i  in  1  system clock (FCLK_CLK0 domain)
reset_i  in  1  synchronous active-high reset
arm_i  in  1  one-cycle arm pulse
disarm_i  in  1  one-cycle disarm pulse
enable_i  in  1  capture gate, level
frame_i  in  1  frame boundary, rising edge active
capture_i  in  1  capture strobe, rising edge active
mode_i  in  2  0=immediate, 1=framed, 2=framed-difference, 3=reserved (treated as 0)
value_i  in  NCH*32  channel values; channel c in bits [32c+31:32c]
dout_o  out  32  stream data word
dout_valid_o  out  1  stream valid
dout_ready_i  in  1  stream ready
active_o  out  1  high while ARMED or RUN
err_o  out  2  0=none, 1=FIFO overflow, 2=double capture in frame, 3=capture too fast
sample_count_o  out  CNT_W  samples written since last arm

Behaviour:
- Reset: all outputs 0, FIFO flushed, state IDLE, err_o=0, sample_count_o=0, latches cleared.
- Edge detect: registered previous copy of enable/frame/capture. On arm, previous copy loads current inputs, so no spurious edge in the first cycle.
- States: IDLE, ARMED, RUN.
  - IDLE -> ARMED on arm_i. This clears err_o and sample_count_o.
  - ARMED -> RUN when enable_i=1.
  - RUN -> IDLE on enable_i falling, disarm_i, or any error.
  - ARMED -> IDLE on disarm_i.
  - arm_i and disarm_i in the same cycle: disarm wins.
  - mode_i is sampled on arm and held for the whole run.
- Capture is recognised only in RUN with enable_i=1 on the same cycle.
- Sample size: NW = NCH words (NCH+1 with timestamp option).
- Mode 0 (immediate):
  - A capture rising edge latches all value_i on that clock edge.
  - The serialiser writes channel 0..NCH-1, one word per cycle, starting the next cycle.
  - With the FIFO empty, dout_valid_o rises 2 clocks after the edge-sampling clock.
- Mode 1 (framed):
  - A capture edge latches values into a pending slot and sets the pending flag.
  - A frame rising edge with pending=1 serialises the slot and clears pending.
  - A frame edge with pending=0 produces no output.
  - A second capture while pending=1 sets err=2.
  - Frame and capture edges in the same cycle: the frame is processed first (emits the old slot), then the capture fills a fresh slot.
- Mode 2 (framed-difference):
  - As mode 1, but each word is value at capture minus value latched at the previous frame edge, mod 2^32.
  - The frame-start value is reloaded on every frame edge, and on RUN entry.
- Overflow:
  - At serialisation start, if FIFO free space < NW, set err=1 and drop the whole sample. No partial writes.
- Capture too fast:
  - A capture (mode 0) or frame (modes 1/2) edge while the serialiser is busy sets err=3 and drops it. The in-flight sample completes.
- Error handling:
  - err_o holds its first nonzero code until next arm.
  - An error forces IDLE after any in-flight serialisation completes.
- sample_count_o increments once per completed sample (last word written) and saturates at all-ones.
- Output stream:
  - dout_o/dout_valid_o are driven from the FIFO head, first-word-fall-through.
  - The word is held stable while valid=1 and ready=0.
  - A transfer occurs when valid and ready are both 1.
  - The FIFO keeps draining in IDLE.
  - Simultaneous FIFO read and write when full is allowed.
- active_o = (state != IDLE).
- Reset mid-run: immediate return to IDLE, FIFO contents discarded, dout_valid_o=0 the next cycle.

Optional Feature:
PCAP_FRAME_TIMESTAMP_EN:
- Defined: a free-running 32-bit cycle counter is cleared on RUN entry. Its value at the capture edge is appended as word NW-1 after the channels, so NW=NCH+1.
- Undefined: counter absent, NW=NCH.

Test Plan:
1. NCH=4, mode 0, values 0x11/0x22/0x33/0x44, arm, enable=1, one capture edge, ready=1. Required: 4 words 0x11,0x22,0x33,0x44, first valid 2 clocks after the edge; sample_count=1.
2. Mode 1: capture at value 100, frame edge later, frame edge again with no capture. Required: one sample with value 100, no second sample, err=0.
3. Mode 2: frame at value 1000, capture at 1250, frame. Required: word 250. Then frame at 0x00000010, capture at 0x00000005, frame. Required: word 0xFFFFFFF5.
4. Mode 0, dout_ready_i=0, FIFO_DEPTH=32, NCH=4, 9 spaced captures. Required: 8 samples stored, err=1, state IDLE; releasing ready drains exactly 32 words.
5. Two capture edges 2 cycles apart in mode 0. Required: err=3, only the first sample emitted. Separately: two captures inside one frame in mode 1 give err=2.
6. Reset asserted mid-serialisation, and arm+disarm in the same cycle. Required: all outputs 0 and FIFO empty next cycle; the latter leaves active_o=0.
